// File: rtl/image_stream_framer_if.sv
// image_stream_framer_if: bundles the control, pixel-input and beat-output signals of
// image_stream_framer.
//   master : the environment side; drives start/num_images, the pixel stream and beat_ready.
//   slave  : the framer side; drives pixel_ready, the beat outputs and the status outputs.
// Signals:
//   start, num_images                       run control
//   pixel_data, pixel_valid, pixel_ready    input pixel stream handshake
//   beat_data, beat_valid, beat_ready       packed output beat handshake
//   beat_sop, beat_eop, beat_image          beat tags
//   beat_checksum                           per-image pixel sum (valid on eop beats)
//   image_done, busy, all_done              status
`timescale 1ns/1ps

interface image_stream_framer_if #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned LANES = 4,
    parameter int unsigned IDX_W = 16
);
    logic                   start;
    logic [IDX_W-1:0]       num_images;
    logic [PIX_W-1:0]       pixel_data;
    logic                   pixel_valid;
    logic                   pixel_ready;
    logic [LANES*PIX_W-1:0] beat_data;
    logic                   beat_valid;
    logic                   beat_ready;
    logic                   beat_sop;
    logic                   beat_eop;
    logic [IDX_W-1:0]       beat_image;
    logic [15:0]            beat_checksum;
    logic                   image_done;
    logic                   busy;
    logic                   all_done;

    modport master (
        output start, num_images, pixel_data, pixel_valid, beat_ready,
        input  pixel_ready, beat_data, beat_valid, beat_sop, beat_eop, beat_image,
               beat_checksum, image_done, busy, all_done
    );

    modport slave (
        input  start, num_images, pixel_data, pixel_valid, beat_ready,
        output pixel_ready, beat_data, beat_valid, beat_sop, beat_eop, beat_image,
               beat_checksum, image_done, busy, all_done
    );
endinterface

// File: rtl/image_stream_framer.sv
// image_stream_framer: accepts a valid/ready pixel stream, delimits it into images of
// PIXELS_PER_IMAGE pixels and packs LANES pixels per output beat (lane 0 in the LSBs), tagging
// each beat with image index, start-of-image and end-of-image.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      image_stream_framer_if.slave (control, pixel input, beat output, status)
// Optional feature: define FRAMER_CHECKSUM_EN to build a 16-bit per-image pixel sum reported
// on the eop beat; otherwise beat_checksum is tied to 0.
`timescale 1ns/1ps

module image_stream_framer #(
    parameter int unsigned PIX_W            = 8,
    parameter int unsigned LANES            = 4,
    parameter int unsigned PIXELS_PER_IMAGE = 256,
    parameter int unsigned IDX_W            = 16
) (
    input logic                  clk,
    input logic                  reset_n,
    image_stream_framer_if.slave bus
);

    localparam int unsigned LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned PIX_CNT_W = (PIXELS_PER_IMAGE > 1) ? $clog2(PIXELS_PER_IMAGE) : 1;
    localparam int unsigned BEAT_W    = LANES * PIX_W;

    localparam logic [LANE_W-1:0]    LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [PIX_CNT_W-1:0] LAST_PIX  = PIX_CNT_W'(PIXELS_PER_IMAGE - 1);
    localparam logic [PIX_CNT_W-1:0] SOP_PIX   = PIX_CNT_W'(LANES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e state_q, state_d;

    logic [IDX_W-1:0]     num_q,       num_d;
    logic [PIX_CNT_W-1:0] pix_cnt_q,   pix_cnt_d;
    logic [IDX_W-1:0]     img_cnt_q,   img_cnt_d;
    logic [LANE_W-1:0]    lane_cnt_q,  lane_cnt_d;
    logic [BEAT_W-1:0]    asm_q,       asm_d;
    logic [BEAT_W-1:0]    beat_data_q, beat_data_d;
    logic                 beat_valid_q, beat_valid_d;
    logic                 sop_q,        sop_d;
    logic                 eop_q,        eop_d;
    logic [IDX_W-1:0]     image_q,      image_d;
    logic [15:0]          checksum_q,   checksum_d;
    logic                 image_done_q, image_done_d;
    logic                 all_done_q,   all_done_d;

    logic                 run;
    logic                 start_ok;
    logic                 last_lane;
    logic                 pixels_left;
    logic                 pixel_ready;
    logic                 accept;
    logic                 beat_load;
    logic                 beat_hs;
    logic                 eop_hs;
    logic                 final_hs;
    logic [BEAT_W-1:0]    word_in;
    logic [15:0]          checksum_load;

    assign run       = (state_q == StRun);
    assign start_ok  = bus.start && !run;
    assign last_lane = (lane_cnt_q == LAST_LANE);
    // Once every pixel of the run is in, stop consuming so surplus input stays with the source.
    assign pixels_left = (img_cnt_q != num_q);
    // The lane that completes a beat may only be taken if the output register can take it.
    assign pixel_ready = run && pixels_left && (!last_lane || !beat_valid_q || bus.beat_ready);
    assign accept      = bus.pixel_valid && pixel_ready;
    assign beat_load   = accept && last_lane;
    assign beat_hs     = beat_valid_q && bus.beat_ready;
    assign eop_hs      = beat_hs && eop_q;
    assign final_hs    = eop_hs && (image_q == (num_q - 1'b1));

    // Assembly word with the incoming pixel dropped into its lane.
    always_comb begin
        word_in = asm_q;
        word_in[lane_cnt_q * PIX_W +: PIX_W] = bus.pixel_data;
    end

`ifdef FRAMER_CHECKSUM_EN
    logic [15:0] sum_q;
    logic [15:0] sum_next;

    // The first pixel of an image restarts the sum, so no separate clear at sop is needed.
    assign sum_next = ((pix_cnt_q == '0) ? 16'd0 : sum_q) + 16'(bus.pixel_data);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_q <= '0;
        end else if (start_ok) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= sum_next;
        end
    end

    assign checksum_load = (pix_cnt_q == LAST_PIX) ? sum_next : 16'd0;
`else
    assign checksum_load = 16'd0;
`endif

    // Run-level state machine.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    state_d = (bus.num_images == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (final_hs) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Counters, assembly and output register.
    always_comb begin
        num_d        = num_q;
        pix_cnt_d    = pix_cnt_q;
        img_cnt_d    = img_cnt_q;
        lane_cnt_d   = lane_cnt_q;
        asm_d        = asm_q;
        beat_data_d  = beat_data_q;
        beat_valid_d = beat_valid_q;
        sop_d        = sop_q;
        eop_d        = eop_q;
        image_d      = image_q;
        checksum_d   = checksum_q;
        image_done_d = eop_hs;
        all_done_d   = all_done_q;

        if (start_ok) begin
            num_d      = bus.num_images;
            pix_cnt_d  = '0;
            img_cnt_d  = '0;
            lane_cnt_d = '0;
            asm_d      = '0;
            all_done_d = (bus.num_images == '0);
        end else begin
            if (final_hs) begin
                all_done_d = 1'b1;
            end
            if (accept) begin
                asm_d      = word_in;
                lane_cnt_d = last_lane ? '0 : lane_cnt_q + 1'b1;
                if (pix_cnt_q == LAST_PIX) begin
                    pix_cnt_d = '0;
                    img_cnt_d = img_cnt_q + 1'b1;
                end else begin
                    pix_cnt_d = pix_cnt_q + 1'b1;
                end
            end
        end

        // A completing beat wins over a handshake on the same edge: the register reloads and
        // beat_valid stays high. Beats never straddle images, so the tags follow from the
        // counters as they stand at the last lane.
        if (beat_load) begin
            beat_data_d  = word_in;
            beat_valid_d = 1'b1;
            sop_d        = (pix_cnt_q == SOP_PIX);
            eop_d        = (pix_cnt_q == LAST_PIX);
            image_d      = img_cnt_q;
            checksum_d   = checksum_load;
        end else if (beat_hs) begin
            beat_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            num_q        <= '0;
            pix_cnt_q    <= '0;
            img_cnt_q    <= '0;
            lane_cnt_q   <= '0;
            asm_q        <= '0;
            beat_data_q  <= '0;
            beat_valid_q <= 1'b0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            image_q      <= '0;
            checksum_q   <= '0;
            image_done_q <= 1'b0;
            all_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_q        <= num_d;
            pix_cnt_q    <= pix_cnt_d;
            img_cnt_q    <= img_cnt_d;
            lane_cnt_q   <= lane_cnt_d;
            asm_q        <= asm_d;
            beat_data_q  <= beat_data_d;
            beat_valid_q <= beat_valid_d;
            sop_q        <= sop_d;
            eop_q        <= eop_d;
            image_q      <= image_d;
            checksum_q   <= checksum_d;
            image_done_q <= image_done_d;
            all_done_q   <= all_done_d;
        end
    end

    assign bus.pixel_ready   = pixel_ready;
    assign bus.beat_data     = beat_data_q;
    assign bus.beat_valid    = beat_valid_q;
    assign bus.beat_sop      = sop_q;
    assign bus.beat_eop      = eop_q;
    assign bus.beat_image    = image_q;
    assign bus.beat_checksum = checksum_q;
    assign bus.image_done    = image_done_q;
    assign bus.busy          = run;
    assign bus.all_done      = all_done_q;

endmodule
